// File: rtl/cond_flag_pkg.sv
// Shared definitions for the condition-flag tracker: rule-select encoding
// and the counter saturation helper.
package cond_flag_pkg;

  typedef enum logic [2:0] {
    RULE_CLR  = 3'd0,
    RULE_HOLD = 3'd1,
    RULE_H    = 3'd2,
    RULE_I    = 3'd3,
    RULE_J    = 3'd4,
    RULE_FALL = 3'd5
  } rule_e;

  function automatic logic [31:0] sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/cond_flag_chan.sv
// One tracker channel: h/i/j flags updated by a fixed priority chain, a
// registered copy of f and a saturating counter of f rising edges.
module cond_flag_chan
  import cond_flag_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter bit STICKY = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             f,
  output logic             h,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_max(CNT_W));

  logic             h_q, i_q, j_q, f_q;
  logic             h_d, i_d, j_d, f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rule_e            rule;

  // Rule 4 looks at the registered h, so a freshly set h cannot block it
  // in the same edge.
  always_comb begin
    rule = RULE_FALL;
    if (clr)                      rule = RULE_CLR;
    else if (!en)                 rule = RULE_HOLD;
    else if (!a && !c)            rule = RULE_H;
    else if (a && !h_q && !b)     rule = RULE_I;
    else if (a && b && c)         rule = RULE_J;
  end

  always_comb begin
    h_d   = h_q;
    i_d   = i_q;
    j_d   = j_q;
    cnt_d = cnt_q;
    case (rule)
      RULE_CLR: begin
        h_d   = 1'b0;
        i_d   = 1'b0;
        j_d   = 1'b0;
        cnt_d = '0;
      end
      RULE_H: h_d = 1'b1;
      RULE_I: i_d = 1'b1;
      RULE_J: j_d = 1'b1;
      RULE_FALL: begin
        if (!STICKY) begin
          h_d = 1'b0;
          i_d = 1'b0;
          j_d = 1'b0;
        end
      end
      default: ;
    endcase
    f_d = i_d | j_d;
    // A clear forces f_d low, so it can never count a rising edge.
    if (f_d && !f_q && (cnt_q != SAT))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q   <= 1'b0;
      i_q   <= 1'b0;
      j_q   <= 1'b0;
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      h_q   <= h_d;
      i_q   <= i_d;
      j_q   <= j_d;
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign f   = i_q | j_q;
  assign h   = h_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/cond_flag_tracker.sv
// Multi-channel registered condition-flag tracker: NUM_CH independent
// channels plus the global OR and packed counter bus.
module cond_flag_tracker
  import cond_flag_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4,
  parameter bit STICKY = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [NUM_CH-1:0]       a,
  input  logic [NUM_CH-1:0]       b,
  input  logic [NUM_CH-1:0]       c,
  output logic [NUM_CH-1:0]       f,
  output logic                    any_f,
  output logic [NUM_CH*CNT_W-1:0] evt_cnt,
  output logic [NUM_CH-1:0]       h_mon
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    cond_flag_chan #(
      .CNT_W  (CNT_W),
      .STICKY (STICKY)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clr   (clr[k]),
      .a     (a[k]),
      .b     (b[k]),
      .c     (c[k]),
      .f     (f[k]),
      .h     (h_mon[k]),
      .cnt   (evt_cnt[k*CNT_W +: CNT_W])
    );
  end

  assign any_f = |f;

endmodule

// File: doc/cond_flag_tracker.md
Name: cond_flag_tracker

Overview:
- Registered, multi-channel successor to the team's combinational priority-condition flag logic.
- Each channel evaluates three input bits (a, b, c) against a fixed priority chain every enabled clock and updates three state flags: h_flag, i_flag and j_flag.
- The channel result f = i_flag | j_flag.
- A saturating counter per channel counts rising edges of f.
- The block sits between the sampled condition inputs and the status/interrupt logic.

Parameters:
- NUM_CH, 4, number of independent channels (1..32).
- CNT_W, 4, width of each per-channel f-event counter (2..16).
- STICKY, 0, 0 = the fall-through branch clears all flags of the channel; 1 = the fall-through branch holds the flags.

Ports:
- clk  in  1  single block clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global evaluate enable; 0 freezes all state.
- clr  in  NUM_CH  per-channel synchronous clear.
- a  in  NUM_CH  condition input A, one bit per channel.
- b  in  NUM_CH  condition input B, one bit per channel.
- c  in  NUM_CH  condition input C, one bit per channel.
- f  out  NUM_CH  per-channel result, i_flag | j_flag.
- any_f  out  1  OR of all f bits.
- evt_cnt  out  NUM_CH*CNT_W  packed counters; channel k occupies bits [k*CNT_W +: CNT_W].
- h_mon  out  NUM_CH  current h_flag per channel, for debug and verification.

Behaviour:
- Reset: rst_n low asynchronously clears h_flag, i_flag, j_flag, f_q and every counter to 0. Consequently f=0, any_f=0, evt_cnt=0, h_mon=0. All outputs are stable from the reset assertion onward.
- Per channel k, at each rising clk, the first matching rule in this order applies:
  1. clr[k]=1: clear h, i, j and the counter. clr overrides en.
  2. en=0: hold all state.
  3. ~a & ~c: h<=1; i and j hold.
  4. a & ~h_q & ~b: i<=1; h and j hold. h_q is the registered h from before this edge; the newly set h is never used within the same edge.
  5. a & b & c: j<=1; h and i hold.
  6. Otherwise, STICKY=0: h, i and j <= 0. STICKY=1: all flags hold.
- Output timing:
  - f[k] = i_q | j_q, taken combinationally from the flag registers.
  - Latency: inputs sampled at edge n are reflected on f after edge n (one clock).
  - any_f is combinational from f.
- Counter:
  - Per channel, the counter increments when the edge produces a 0->1 transition of f (f_next=1 and f_q=0).
  - It saturates at 2^CNT_W-1 and does not wrap.
  - A clr in the same cycle as a rising f wins: the counter goes to 0, the flags go to 0, and no count is taken.
- Channels are fully independent. Simultaneous events on several channels are all processed in the same edge.
- A reset asserted in the middle of any sequence aborts it. After release, the first enabled edge evaluates from the all-zero state.
- Inputs are assumed synchronous to clk. No internal synchronisers.

Decomposition:
- Shared package cond_flag_pkg holds:
  - the rule-select encoding for debug/assertions: RULE_CLR, RULE_HOLD, RULE_H, RULE_I, RULE_J, RULE_FALL as a 3-bit enum;
  - a function that returns the saturation value for a given CNT_W.
- Sub-module cond_flag_chan implements one channel: three flags, the f register and the saturating counter. The top level instantiates it NUM_CH times in a generate loop and builds any_f and the packed evt_cnt.

Test Plan:
- Reset, then drive a=0, c=0 on channel 0 with en=1 -> after 1 edge h_mon[0]=1, f[0]=0, evt_cnt ch0=0.
- From reset, a=1, b=0, c=1 on channel 1 -> after 1 edge f[1]=1, any_f=1, ch1 count=1.
  - Next edge with a=0, b=0, c=1 (fall-through), STICKY=0 -> f[1]=0, count stays 1.
  - With STICKY=1, the same sequence -> f[1] stays 1.
- Priority check on channel 2, run from reset:
  - Edge 1: a=0, c=0 sets h.
  - Edge 2: a=1, b=0, c=1 hits the fall-through (rule 4 blocked because h_q=1) -> all flags clear when STICKY=0, f[2]=0.
  - Edge 3: the same vector with h_q=0 -> i=1, f[2]=1.
- Saturation with CNT_W=4 on channel 3: toggle a=b=c=1 (sets j) and a=0, b=0, c=1 (fall-through) for 20 rising-f events -> counter stops at 15.
  - clr[3] pulse -> counter=0, f[3]=0 on the next edge.
- en=0 while a/b/c toggle on all channels for 5 cycles -> f, h_mon and evt_cnt unchanged.
  - Then assert rst_n=0 between edges -> all outputs 0 immediately, without waiting for an edge.
